// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, control-unit state encodings and
// next-PC select codes used by the fetch stage and the control unit.
package cpu_pkg;

  // Opcode field is instruction bits [15:10]
  localparam logic [5:0] OP_NOP  = 6'b000000;
  localparam logic [5:0] OP_JMP  = 6'b110000;
  localparam logic [5:0] OP_CALL = 6'b110001;
  localparam logic [5:0] OP_RET  = 6'b110010;
  localparam logic [5:0] OP_RETI = 6'b110011;
  localparam logic [5:0] OP_LDM  = 6'b101000;

  // Interrupt sequence states; INT_ACCEPT means the CU took the request
  localparam logic [1:0] INT_IDLE    = 2'b00;
  localparam logic [1:0] INT_ACCEPT  = 2'b01;
  localparam logic [1:0] INT_PUSH_HI = 2'b10;
  localparam logic [1:0] INT_PUSH_LO = 2'b11;

  // RET / RETI sequence states; zero is always idle
  localparam logic [2:0] RET_IDLE  = 3'b000;
  localparam logic [2:0] RET_POP1  = 3'b001;
  localparam logic [2:0] RET_POP2  = 3'b010;
  localparam logic [2:0] RET_LOAD  = 3'b011;
  localparam logic [2:0] RETI_IDLE = 3'b000;
  localparam logic [2:0] RETI_POP1 = 3'b001;
  localparam logic [2:0] RETI_POP2 = 3'b010;
  localparam logic [2:0] RETI_LOAD = 3'b011;

  // Next-PC select
  localparam logic [1:0] JS_SEQ = 2'b00;
  localparam logic [1:0] JS_JMP = 2'b01;
  localparam logic [1:0] JS_INT = 2'b10;
  localparam logic [1:0] JS_RET = 2'b11;

endpackage

// File: rtl/irq_latch.sv
// Interrupt request latch: rising-edge detect on irq, sticky pending flag
// cleared on CU acceptance, and masking while RET/RETI/CALL/interrupt
// sequences are in flight.
module irq_latch
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       irq,
  input  logic [1:0] inter_state_after,
  input  logic [1:0] inter_state_before,
  input  logic [2:0] ret_state_before,
  input  logic [2:0] reti_state_before,
  input  logic       inst_before_call,
  output logic       interrupt
);

  logic irq_q;
  logic irq_pending;
  logic irq_rise;

  assign irq_rise = irq & ~irq_q;

  // Edge detect and pending flag; a new edge wins over a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q       <= 1'b0;
      irq_pending <= 1'b0;
    end else begin
      irq_q       <= irq;
      irq_pending <= irq_rise | (irq_pending & (inter_state_after != INT_ACCEPT));
    end
  end

  // Masked, not dropped: the request waits until every sequence is idle
  assign interrupt = irq_pending & ~|ret_state_before & ~|reti_state_before
                   & ~inst_before_call & ~|inter_state_before;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, the IF/ID buffer, the registered CU sequence
// states, the second-CALL-cycle flag and the interrupt latch.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter int              INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               irq,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               pc_enable,
  input  logic               f_d_buffer_enable,
  input  logic               flush,
  input  logic [1:0]         jump_sel,
  input  logic [PC_W-1:0]    jump_target,
  input  logic [PC_W-1:0]    int_vector,
  input  logic [PC_W-1:0]    ret_addr,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  input  logic               call_decoded,
  input  logic [1:0]         inter_state_after,
  input  logic [2:0]         ret_state_after,
  input  logic [2:0]         reti_state_after,
  output logic [INSTR_W-1:0] fd_instr,
  output logic [INSTR_W-1:0] fd_imm,
  output logic [PC_W-1:0]    fd_pc_next,
  output logic               fd_valid,
  output logic               interrupt,
  output logic               inst_before_call,
  output logic [1:0]         inter_state_before,
  output logic [2:0]         ret_state_before,
  output logic [2:0]         reti_state_before
);

  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_plus1;
  logic [PC_W-1:0] pc_sel;

  assign imem_addr = pc;
  assign pc_plus1  = pc + PC_W'(1);

  // Control-unit jump select
  always_comb begin
    pc_sel = pc_plus1;
    case (jump_sel)
      JS_SEQ:  pc_sel = pc_plus1;
      JS_JMP:  pc_sel = jump_target;
      JS_INT:  pc_sel = int_vector;
      JS_RET:  pc_sel = ret_addr;
      default: pc_sel = pc_plus1;
    endcase
  end

  // PC register: a resolved branch overrides any CU stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (branch_taken) begin
      pc <= branch_target;
    end else if (pc_enable) begin
      pc <= pc_sel;
    end
  end

  // IF/ID buffer; a flushed word is kept as the LDM immediate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fd_instr   <= '0;
      fd_imm     <= '0;
      fd_pc_next <= RESET_PC;
      fd_valid   <= 1'b0;
    end else if (branch_taken) begin
      fd_instr <= '0;
      fd_valid <= 1'b0;
    end else if (f_d_buffer_enable && flush) begin
      fd_instr <= '0;
      fd_valid <= 1'b0;
      fd_imm   <= imem_data;
    end else if (f_d_buffer_enable) begin
      fd_instr   <= imem_data;
      fd_pc_next <= pc_plus1;
      fd_valid   <= 1'b1;
    end
  end

  // CU sequence states delayed by one cycle, plus the CALL second-cycle flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inter_state_before <= INT_IDLE;
      ret_state_before   <= RET_IDLE;
      reti_state_before  <= RETI_IDLE;
      inst_before_call   <= 1'b0;
    end else begin
      inter_state_before <= inter_state_after;
      ret_state_before   <= ret_state_after;
      reti_state_before  <= reti_state_after;
      inst_before_call   <= call_decoded & ~inst_before_call;
    end
  end

  irq_latch u_irq_latch (
    .clk                (clk),
    .rst_n              (rst_n),
    .irq                (irq),
    .inter_state_after  (inter_state_after),
    .inter_state_before (inter_state_before),
    .ret_state_before   (ret_state_before),
    .reti_state_before  (reti_state_before),
    .inst_before_call   (inst_before_call),
    .interrupt          (interrupt)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by a
// randomized run, all compared against a cycle-level behavioural model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        irq;
  logic [31:0] imem_addr;
  logic [15:0] imem_data;
  logic        pc_enable, f_d_buffer_enable, flush;
  logic [1:0]  jump_sel;
  logic [31:0] jump_target, int_vector, ret_addr, branch_target;
  logic        branch_taken, call_decoded;
  logic [1:0]  inter_state_after;
  logic [2:0]  ret_state_after, reti_state_after;
  logic [15:0] fd_instr, fd_imm;
  logic [31:0] fd_pc_next;
  logic        fd_valid, interrupt, inst_before_call;
  logic [1:0]  inter_state_before;
  logic [2:0]  ret_state_before, reti_state_before;

  logic [15:0] mem [256];

  int passed = 0;
  int total  = 0;
  int accepts;

  // Behavioural model state
  logic [31:0] m_pc, m_pcn;
  logic [15:0] m_instr, m_imm;
  logic        m_valid, m_ibc, m_irqq, m_pend;
  logic [1:0]  m_inter;
  logic [2:0]  m_ret, m_reti;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr[7:0]];

  fetch_unit dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .irq                (irq),
    .imem_addr          (imem_addr),
    .imem_data          (imem_data),
    .pc_enable          (pc_enable),
    .f_d_buffer_enable  (f_d_buffer_enable),
    .flush              (flush),
    .jump_sel           (jump_sel),
    .jump_target        (jump_target),
    .int_vector         (int_vector),
    .ret_addr           (ret_addr),
    .branch_taken       (branch_taken),
    .branch_target      (branch_target),
    .call_decoded       (call_decoded),
    .inter_state_after  (inter_state_after),
    .ret_state_after    (ret_state_after),
    .reti_state_after   (reti_state_after),
    .fd_instr           (fd_instr),
    .fd_imm             (fd_imm),
    .fd_pc_next         (fd_pc_next),
    .fd_valid           (fd_valid),
    .interrupt          (interrupt),
    .inst_before_call   (inst_before_call),
    .inter_state_before (inter_state_before),
    .ret_state_before   (ret_state_before),
    .reti_state_before  (reti_state_before)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    irq = 1'b0; pc_enable = 1'b0; f_d_buffer_enable = 1'b0; flush = 1'b0;
    jump_sel = 2'b00; jump_target = '0; int_vector = 32'h0000_0020; ret_addr = '0;
    branch_taken = 1'b0; branch_target = '0; call_decoded = 1'b0;
    inter_state_after = 2'b00; ret_state_after = 3'b000; reti_state_after = 3'b000;
  endtask

  task automatic model_reset();
    m_pc = '0; m_pcn = '0; m_instr = '0; m_imm = '0; m_valid = 1'b0;
    m_ibc = 1'b0; m_irqq = 1'b0; m_pend = 1'b0;
    m_inter = '0; m_ret = '0; m_reti = '0;
  endtask

  function automatic logic model_int();
    return m_pend && (m_ret == 0) && (m_reti == 0) && !m_ibc && (m_inter == 0);
  endfunction

  task automatic check_comb();
    check("imem_addr", imem_addr, m_pc);
    check("interrupt", 32'(interrupt), 32'(model_int()));
  endtask

  task automatic check_regs();
    check("fd_instr", 32'(fd_instr), 32'(m_instr));
    check("fd_imm", 32'(fd_imm), 32'(m_imm));
    check("fd_pc_next", fd_pc_next, m_pcn);
    check("fd_valid", 32'(fd_valid), 32'(m_valid));
    check("inst_before_call", 32'(inst_before_call), 32'(m_ibc));
    check("inter_state_before", 32'(inter_state_before), 32'(m_inter));
    check("ret_state_before", 32'(ret_state_before), 32'(m_ret));
    check("reti_state_before", 32'(reti_state_before), 32'(m_reti));
  endtask

  // One clock: check outputs before the edge, advance model, check after
  task automatic step();
    logic [31:0] n_pc, n_pcn;
    logic [15:0] n_instr, n_imm, word;
    logic        n_valid, n_ibc, n_pend;
    #1;
    check_comb();
    word    = mem[m_pc[7:0]];
    n_pc    = m_pc;
    n_instr = m_instr; n_imm = m_imm; n_pcn = m_pcn; n_valid = m_valid;
    if (branch_taken) n_pc = branch_target;
    else if (pc_enable) begin
      if (jump_sel == 2'd0)      n_pc = m_pc + 32'd1;
      else if (jump_sel == 2'd1) n_pc = jump_target;
      else if (jump_sel == 2'd2) n_pc = int_vector;
      else                       n_pc = ret_addr;
    end
    if (branch_taken) begin
      n_instr = '0; n_valid = 1'b0;
    end else if (f_d_buffer_enable && flush) begin
      n_instr = '0; n_valid = 1'b0; n_imm = word;
    end else if (f_d_buffer_enable) begin
      n_instr = word; n_pcn = m_pc + 32'd1; n_valid = 1'b1;
    end
    n_ibc  = call_decoded && !m_ibc;
    n_pend = (irq && !m_irqq) || (m_pend && inter_state_after != 2'b01);
    @(posedge clk);
    #1;
    m_pc = n_pc; m_instr = n_instr; m_imm = n_imm; m_pcn = n_pcn; m_valid = n_valid;
    m_ibc = n_ibc; m_pend = n_pend; m_irqq = irq;
    m_inter = inter_state_after; m_ret = ret_state_after; m_reti = reti_state_after;
    check_regs();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_comb();
    check_regs();
    check("reset_pc", imem_addr, 32'h0);
    rst_n = 1'b1;

    // 1. sequential fetch
    pc_enable = 1'b1; f_d_buffer_enable = 1'b1; jump_sel = 2'b00;
    for (int i = 1; i <= 3; i++) begin
      step();
      check("t1_pc", imem_addr, 32'(i));
      check("t1_valid", 32'(fd_valid), 32'd1);
      check("t1_instr", 32'(fd_instr), 32'(mem[i-1]));
    end

    // 2. JMP with squash of the following word
    jump_sel = 2'b01; flush = 1'b1; jump_target = 32'h40;
    step();
    check("t2_pc", imem_addr, 32'h40);
    check("t2_instr", 32'(fd_instr), 32'h0);
    check("t2_valid", 32'(fd_valid), 32'h0);
    check("t2_imm", 32'(fd_imm), 32'(mem[3]));
    flush = 1'b0; jump_target = 32'hFFFF_FFFF;
    step();
    jump_sel = 2'b00;
    step();
    check("t2_wrap_pc", imem_addr, 32'h0);
    check("t2_wrap_pcnext", fd_pc_next, 32'h0);

    // 3. branch overrides a stalled PC
    pc_enable = 1'b0; branch_taken = 1'b1; branch_target = 32'h100;
    step();
    check("t3_pc", imem_addr, 32'h100);
    check("t3_valid", 32'(fd_valid), 32'h0);
    branch_taken = 1'b0; f_d_buffer_enable = 1'b0;
    step();
    check("t3_hold", imem_addr, 32'h100);

    // 4. interrupt masked during RET, then accepted
    ret_state_after = 3'b010;
    step();
    irq = 1'b1;
    step();
    irq = 1'b0;
    #1 check("t4_masked", 32'(interrupt), 32'd0);
    step();
    ret_state_after = 3'b000;
    step();
    inter_state_after = 2'b01;
    #1 check("t4_raised", 32'(interrupt), 32'd1);
    step();
    inter_state_after = 2'b00;
    #1 check("t4_dropped", 32'(interrupt), 32'd0);
    step();

    // 5. level held for 10 cycles gives one acceptance
    accepts = 0;
    irq = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (interrupt) begin
        accepts++;
        inter_state_after = 2'b01;
      end else begin
        inter_state_after = 2'b00;
      end
      step();
    end
    check("t5_accepts", 32'(accepts), 32'd1);
    irq = 1'b0; inter_state_after = 2'b00;
    step();
    irq = 1'b1;
    step();
    irq = 1'b0;
    #1 check("t5_first", 32'(interrupt), 32'd1);
    step();
    irq = 1'b1; inter_state_after = 2'b01;
    step();
    inter_state_after = 2'b00;
    #1 check("t5_in_accept", 32'(interrupt), 32'd0);
    step();
    #1 check("t5_second_pending", 32'(interrupt), 32'd1);
    inter_state_after = 2'b01;
    step();
    irq = 1'b0; inter_state_after = 2'b00;
    step();

    // 6. CALL second cycle, then reset mid-RET
    call_decoded = 1'b1;
    step();
    check("t6_ibc_one", 32'(inst_before_call), 32'd1);
    step();
    check("t6_ibc_not_twice", 32'(inst_before_call), 32'd0);
    call_decoded = 1'b0;
    step();
    ret_state_after = 3'b001; pc_enable = 1'b1; f_d_buffer_enable = 1'b1; irq = 1'b1;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_comb();
    check_regs();
    check("t6_reset_ret", 32'(ret_state_before), 32'd0);
    idle_inputs();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      irq               = ($urandom_range(0, 3) == 0);
      pc_enable         = ($urandom_range(0, 3) != 0);
      f_d_buffer_enable = ($urandom_range(0, 3) != 0);
      flush             = ($urandom_range(0, 3) == 0);
      jump_sel          = 2'($urandom_range(0, 3));
      jump_target       = $urandom;
      int_vector        = $urandom;
      ret_addr          = $urandom;
      branch_taken      = ($urandom_range(0, 7) == 0);
      branch_target     = $urandom;
      call_decoded      = ($urandom_range(0, 3) == 0);
      inter_state_after = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      ret_state_after   = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      reti_state_after  = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
